// File: rtl/adder_4bit_seq_ctrl_if.sv
// Operand/result handshake plus the nibble-wide link to the external adder_4bit.
// master drives operands, accepts results and returns the adder's sum/cout; slave is the sequencer.
interface adder_4bit_seq_ctrl_if #(
  parameter int NIBBLES = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic [4*NIBBLES-1:0]   in_a;
  logic [4*NIBBLES-1:0]   in_b;
  logic                   in_cin;
  logic [3:0]             add_a;
  logic [3:0]             add_b;
  logic                   add_cin;
  logic [3:0]             add_sum;
  logic                   add_cout;
  logic                   out_valid;
  logic                   out_ready;
  logic [4*NIBBLES-1:0]   out_sum;
  logic                   out_cout;
  logic                   busy;

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready, add_sum, add_cout,
    input  in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready, add_sum, add_cout,
    output in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout, busy
  );
endinterface

// File: rtl/adder_4bit_seq_ctrl.sv
// Ripples a wide add through an external 4-bit adder, one nibble per cycle LSB first.
// Result valid NIBBLES cycles after accept; held in DONE until out_ready; no new operands until back in IDLE.
module adder_4bit_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  adder_4bit_seq_ctrl_if.slave  bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state;
  logic [IW-1:0]  idx;
  logic           carry;
  logic [W-1:0]   a_reg;
  logic [W-1:0]   b_reg;
  logic [W-1:0]   sum_reg;
  logic           cout_reg;
  logic           valid_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg <= bus.in_a;
            b_reg <= bus.in_b;
            carry <= bus.in_cin;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum_reg[4*idx +: 4] <= bus.add_sum;
          carry               <= bus.add_cout;
          if (idx == LAST) begin
            idx       <= '0;
            cout_reg  <= bus.add_cout;
            valid_reg <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            valid_reg <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Adder inputs come only from registers, so there is no in_* to add_* combinational path.
  assign bus.add_a     = (state == RUN) ? a_reg[4*idx +: 4] : 4'd0;
  assign bus.add_b     = (state == RUN) ? b_reg[4*idx +: 4] : 4'd0;
  assign bus.add_cin   = (state == RUN) ? carry : 1'b0;
  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = valid_reg;
  assign bus.out_sum   = sum_reg;
  assign bus.out_cout  = cout_reg;
endmodule
